uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning i_Clock cycles per serial bit.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of byte slots; it is a power of two, minimum 2.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port KEY_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_Wr_DV, input, 1 bit: one-cycle byte write strobe.
REQ-006 SHALL have port i_Wr_Byte, input, 8 bits: byte to enqueue.
REQ-007 SHALL have port o_Full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-008 SHALL have port o_Empty, output, 1 bit: FIFO holds 0 bytes.
REQ-009 SHALL have port o_Count, output, clog2(FIFO_DEPTH)+1 bits: bytes queued, excluding the byte in flight.
REQ-010 SHALL have port o_Overflow, output, 1 bit: sticky flag, a write was dropped.
REQ-011 SHALL have port o_Tx_Serial, output, 1 bit: UART line, idle high.
REQ-012 SHALL have port o_Tx_Active, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port o_Tx_Done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 A write SHALL enqueue i_Wr_Byte when i_Wr_DV=1 and o_Full=0 (pre-edge value); a pop in the same cycle does not make room for that write.
REQ-015 When i_Wr_DV=1 and o_Full=1, the write SHALL be discarded and o_Overflow set to 1 until reset.
REQ-016 A simultaneous write and pop SHALL leave o_Count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE with o_Empty=0, the FSM SHALL pop the head byte into a shift register and enter START on the same edge; o_Tx_Serial goes 0 and o_Tx_Active goes 1 at that edge.
REQ-019 Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE SHALL drive the start bit from edge k+1.
REQ-020 Each bit (start, data, parity, stop) SHALL be held for exactly CLKS_PER_BIT cycles.
REQ-021 The 8 data bits SHALL be sent LSB first.
REQ-022 START SHALL transition to DATA; DATA SHALL transition to PARITY when enabled (REQ-029), else to STOP; STOP SHALL transition to IDLE.
REQ-023 The stop bit SHALL be 1; o_Tx_Done SHALL pulse high during the final cycle of STOP.
REQ-024 o_Tx_Active SHALL fall on the edge that enters IDLE.
REQ-025 Back-to-back frames SHALL have exactly one IDLE cycle (line high) between them.
REQ-026 A write is accepted while a frame is in flight; the in-flight byte SHALL NOT be disturbed.

Reset
REQ-027 On KEY_rst=0 (asynchronous), all state SHALL reset immediately: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Full=0, o_Empty=1, o_Count=0, o_Overflow=0, FSM in IDLE, pointers 0.
REQ-028 Reset mid-frame SHALL abort the frame, return the line high at once and discard all queued bytes; operation resumes on the first rising edge after release.

Configuration
REQ-029 With macro UART_TX_FIFO_PARITY_EN defined, one even-parity bit (XOR of the 8 data bits) SHALL be sent between the last data bit and the stop bit, giving an 11-bit frame; without it, no parity state is reachable and the frame is 10 bits.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-030 Write 0xA5 from idle -> start bit one cycle later; line reads 0,1,0,1,0,0,1,0,1,1 at 4 cycles each; o_Tx_Done pulses once at cycle 40 of the frame.
REQ-031 Write 10 bytes on consecutive cycles from idle -> byte0 sent first; bytes 1-8 queued; o_Full=1 and o_Count=8 after the 9th write; 10th byte dropped; o_Overflow=1; output order is bytes 0-8.
REQ-032 Queue 3 bytes -> three frames, each separated by exactly one high idle cycle; o_Empty=1 after the third pop; o_Tx_Active low after the third stop.
REQ-033 Assert KEY_rst=0 during data bit 3 of a frame with 4 bytes queued -> line high within the same cycle; o_Count=0; no further frames after release.
REQ-034 With UART_TX_FIFO_PARITY_EN: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo -- byte FIFO feeding an 8-bit UART transmitter.
//
// Bytes written with i_Wr_DV are queued in a FIFO_DEPTH-entry buffer. Whenever
// the transmitter is idle and the FIFO holds data, the head byte is popped and
// sent as start bit, 8 data bits LSB first, optional even parity, and a stop
// bit. Each bit is held for CLKS_PER_BIT clocks.
//
// Optional feature macro: UART_TX_FIFO_PARITY_EN
//   defined   -> 11-bit frame with an even-parity bit before the stop bit
//   undefined -> 10-bit frame, PARITY state never entered
//
// Ports
//   i_Clock     in   clock, rising edge
//   KEY_rst     in   asynchronous active-low reset
//   i_Wr_DV     in   one-cycle write strobe
//   i_Wr_Byte   in   [7:0] byte to enqueue
//   o_Full      out  FIFO holds FIFO_DEPTH bytes
//   o_Empty     out  FIFO holds no bytes
//   o_Count     out  [clog2(FIFO_DEPTH):0] bytes queued (excludes byte in flight)
//   o_Overflow  out  sticky: a write arrived while full and was dropped
//   o_Tx_Serial out  UART line, idle high
//   o_Tx_Active out  frame in progress
//   o_Tx_Done   out  one-cycle pulse during the last cycle of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          i_Clock,
   input  logic                          KEY_rst,
   input  logic                          i_Wr_DV,
   input  logic [7:0]                    i_Wr_Byte,
   output logic                          o_Full,
   output logic                          o_Empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_Count,
   output logic                          o_Overflow,
   output logic                          o_Tx_Serial,
   output logic                          o_Tx_Active,
   output logic                          o_Tx_Done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   // ---------------- FIFO ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          wr_en, pop;

   assign o_Full   = (count == CNT_FULL);
   assign o_Empty  = (count == '0);
   assign o_Count  = count;
   // Full is judged on the pre-edge count, so a same-cycle pop never frees
   // a slot for the write.
   assign wr_en    = i_Wr_DV && !o_Full;

   always_ff @(posedge i_Clock) begin
      if (wr_en) mem[wr_ptr] <= i_Wr_Byte;
   end

   // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH on their own.
   always_ff @(posedge i_Clock or negedge KEY_rst) begin
      if (!KEY_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_Overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (i_Wr_DV && o_Full) o_Overflow <= 1'b1;
      end
   end

   // ---------------- transmitter ----------------
   state_t        state, state_n;
   logic [CW-1:0] clk_cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    tx_byte, byte_n;
   logic          serial_n, active_n;
   logic          bit_end;

   assign bit_end   = (clk_cnt == CNT_LAST);
   assign o_Tx_Done = (state == STOP) && bit_end;

   always_ff @(posedge i_Clock or negedge KEY_rst) begin
      if (!KEY_rst) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         tx_byte     <= '0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
      end else begin
         state       <= state_n;
         clk_cnt     <= cnt_n;
         bit_idx     <= bit_n;
         tx_byte     <= byte_n;
         o_Tx_Serial <= serial_n;
         o_Tx_Active <= active_n;
      end
   end

   // The line and active flag are registered: each branch sets the value the
   // line must carry for the bit that starts on this edge.
   always_comb begin
      state_n  = state;
      cnt_n    = bit_end ? '0 : clk_cnt + 1'b1;
      bit_n    = bit_idx;
      byte_n   = tx_byte;
      serial_n = o_Tx_Serial;
      active_n = o_Tx_Active;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            cnt_n    = '0;
            bit_n    = '0;
            serial_n = 1'b1;
            active_n = 1'b0;
            if (!o_Empty) begin
               pop      = 1'b1;
               byte_n   = mem[rd_ptr];
               state_n  = START;
               serial_n = 1'b0;
               active_n = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_n  = DATA;
               bit_n    = '0;
               serial_n = tx_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
                  state_n  = PARITY;
                  serial_n = ^tx_byte;
`else
                  state_n  = STOP;
                  serial_n = 1'b1;
`endif
               end else begin
                  bit_n    = bit_idx + 3'd1;
                  serial_n = tx_byte[bit_idx + 3'd1];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n  = STOP;
               serial_n = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_n  = IDLE;
               serial_n = 1'b1;
               active_n = 1'b0;
            end
         end
         default: begin
            state_n  = IDLE;
            serial_n = 1'b1;
            active_n = 1'b0;
         end
      endcase
   end

endmodule
